// File: rtl/pagerank_scatter_if.sv
// Memory-read and gather-stream bus of the PageRank scatter engine.
// The master side is the scatter engine; the slave side is the CSR
// memories plus the gather consumer.
interface pagerank_scatter_if;
    logic [31:0] offset_addr;
    logic [31:0] offset_data;
    logic [31:0] edge_addr;
    logic [31:0] edge_data;
    logic [63:0] page_rank_scatter;
    logic [31:0] dest_id;
    logic        pagerank_ready;

    modport master (
        output offset_addr,
        output edge_addr,
        output page_rank_scatter,
        output dest_id,
        output pagerank_ready,
        input  offset_data,
        input  edge_data
    );

    modport slave (
        input  offset_addr,
        input  edge_addr,
        input  page_rank_scatter,
        input  dest_id,
        input  pagerank_ready,
        output offset_data,
        output edge_data
    );
endinterface

// File: rtl/pagerank_scatter.sv
// PageRank scatter engine: walks a CSR graph node by node, divides each
// node's rank by its out-degree and streams (contribution, dest_id) pairs
// to the gather, one per cycle, then raises scatter_operation_complete.
module pagerank_scatter #(
    parameter int NODES_IN_GRAPH = 32,
    parameter int EDGES_IN_GRAPH = 128
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [64*NODES_IN_GRAPH-1:0] rank_in,
    pagerank_scatter_if.master           bus,
    output logic                         scatter_operation_complete,
    output logic                         busy,
    output logic                         bad_dest
);

    localparam logic [31:0] NODE_LIMIT = 32'(NODES_IN_GRAPH);
    localparam logic [31:0] EDGE_LIMIT = 32'(EDGES_IN_GRAPH);
    localparam logic [31:0] LAST_NODE  = 32'(NODES_IN_GRAPH - 1);

    typedef enum logic [3:0] {
        IDLE, LD_BASE, BASE_WAIT, HDR, HDR_WAIT, DIV, EMIT, DRAIN, NEXT, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] s;
    logic [31:0] edge_begin, edge_end, e;
    logic [5:0]  cnt;
    logic [31:0] rem, divisor;
    logic [63:0] quo;
    logic [63:0] rank_sel;
    logic [31:0] end_clamped;
    logic        dangling;
    logic        start_ok;
    logic        vld_p1;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    function automatic logic [95:0] div_step(input logic [31:0] r,
                                             input logic [63:0] q,
                                             input logic [31:0] d);
        logic [32:0] trial;
        trial = {r, q[63]};
        if (trial >= {1'b0, d})
            return {32'(trial - {1'b0, d}), q[62:0], 1'b1};
        else
            return {trial[31:0], q[62:0], 1'b0};
    endfunction

    // Rank of the current source node.
    always_comb begin
        rank_sel = '0;
        for (int i = 0; i < NODES_IN_GRAPH; i++)
            if (s == 32'(i)) rank_sel = rank_in[i*64 +: 64];
    end

    // Header decode: an offset past the edge memory is clamped so the walk
    // never leaves it; end <= begin covers both dangling and malformed nodes.
    always_comb begin
        end_clamped = (bus.offset_data > EDGE_LIMIT) ? EDGE_LIMIT : bus.offset_data;
        dangling    = (end_clamped <= edge_begin);
        start_ok    = start && (state == IDLE || state == DONE);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = LD_BASE;
            LD_BASE:   state_nxt = BASE_WAIT;
            BASE_WAIT: state_nxt = HDR;
            HDR:       state_nxt = HDR_WAIT;
            HDR_WAIT:  state_nxt = dangling ? NEXT : DIV;
            DIV:       if (cnt == 6'd63) state_nxt = EMIT;
            EMIT:      if (e == edge_end - 32'd1) state_nxt = DRAIN;
            DRAIN:     if (cnt == 6'd1) state_nxt = NEXT;
            NEXT:      state_nxt = (s == LAST_NODE) ? DONE : HDR;
            DONE:      if (start) state_nxt = LD_BASE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: memory addresses and status levels.
    always_comb begin
        bus.offset_addr            = '0;
        bus.edge_addr              = '0;
        busy                       = 1'b1;
        scatter_operation_complete = 1'b0;
        case (state)
            HDR:     bus.offset_addr = s + 32'd1;
            EMIT:    bus.edge_addr   = e;
            IDLE:    busy = 1'b0;
            DONE: begin
                busy                       = 1'b0;
                scatter_operation_complete = 1'b1;
            end
            default: ;
        endcase
    end

    // Traversal cursors and the iterative divider.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s          <= '0;
            edge_begin <= '0;
            edge_end   <= '0;
            e          <= '0;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
        end else begin
            case (state)
                LD_BASE:   s <= '0;
                BASE_WAIT: edge_begin <= bus.offset_data;
                HDR_WAIT: begin
                    edge_end <= end_clamped;
                    if (!dangling) begin
                        rem     <= '0;
                        quo     <= rank_sel;
                        divisor <= end_clamped - edge_begin;
                        cnt     <= '0;
                    end
                end
                DIV: begin
                    {rem, quo} <= div_step(rem, quo, divisor);
                    cnt        <= cnt + 6'd1;
                    if (cnt == 6'd63) e <= edge_begin;
                end
                EMIT: begin
                    e   <= e + 32'd1;
                    cnt <= '0;
                end
                DRAIN: cnt <= cnt + 6'd1;
                NEXT: begin
                    edge_begin <= edge_end;
                    s          <= s + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // ---- stage p0 -> p1: edge address issued, memory read in flight ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_p1 <= 1'b0;
        else          vld_p1 <= (state == EMIT);
    end

    // ---- stage p1 -> p2: destination returned, pair registered to gather ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.pagerank_ready    <= 1'b0;
            bus.dest_id           <= '0;
            bus.page_rank_scatter <= '0;
            bad_dest              <= 1'b0;
        end else begin
            bus.pagerank_ready <= vld_p1 && (bus.edge_data < NODE_LIMIT);
            if (vld_p1) begin
                bus.dest_id           <= bus.edge_data;
                bus.page_rank_scatter <= quo;
            end
            if (start_ok)
                bad_dest <= 1'b0;
            else if (vld_p1 && bus.edge_data >= NODE_LIMIT)
                bad_dest <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pagerank_scatter.sv
// Directed bench for pagerank_scatter on a 2-node graph with registered
// offset/edge memories and a table of hand-computed passes.
module tb_pagerank_scatter;
    localparam int N = 2;
    localparam int E = 8;

    logic           clock, reset_n, start;
    logic [64*N-1:0] rank_in;
    logic           complete, busy, bad_dest;

    pagerank_scatter_if bus();

    pagerank_scatter #(.NODES_IN_GRAPH(N), .EDGES_IN_GRAPH(E)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .start                      (start),
        .rank_in                    (rank_in),
        .bus                        (bus),
        .scatter_operation_complete (complete),
        .busy                       (busy),
        .bad_dest                   (bad_dest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] offset_mem [3];
    logic [31:0] edge_mem [E];

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clock) begin
        bus.offset_data <= (bus.offset_addr < 32'd3) ? offset_mem[bus.offset_addr[1:0]] : 32'd0;
        bus.edge_data   <= (bus.edge_addr < 32'(E)) ? edge_mem[bus.edge_addr[2:0]] : 32'd0;
    end

    typedef struct {
        logic [2:0][31:0] offs;
        logic [3:0][31:0] edges;
        logic [1:0][63:0] rank;
        int               n;
        logic [3:0][63:0] val;
        logic [3:0][31:0] dst;
        bit               bad;
        int               lat;
    } vec_t;

    vec_t vecs [7];
    int checks = 0;
    int failures = 0;

    logic [63:0] got_val [8];
    logic [31:0] got_dst [8];
    logic [31:0] addr_at_first;
    int got_n, first_lat, last_rdy;

    function automatic vec_t mk(input logic [31:0] o0, o1, o2,
                                input logic [31:0] e0, e1, e2, e3,
                                input logic [63:0] r0, r1, input int n,
                                input logic [63:0] v0, v1, v2, v3,
                                input logic [31:0] d0, d1, d2, d3,
                                input bit bad, input int lat);
        vec_t v;
        v.offs[0] = o0; v.offs[1] = o1; v.offs[2] = o2;
        v.edges[0] = e0; v.edges[1] = e1; v.edges[2] = e2; v.edges[3] = e3;
        v.rank[0] = r0; v.rank[1] = r1; v.n = n;
        v.val[0] = v0; v.val[1] = v1; v.val[2] = v2; v.val[3] = v3;
        v.dst[0] = d0; v.dst[1] = d1; v.dst[2] = d2; v.dst[3] = d3;
        v.bad = bad; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.pagerank_ready), 0);
        check({tag, "_value"}, bus.page_rank_scatter, 0);
        check({tag, "_dest"}, 64'(bus.dest_id), 0);
        check({tag, "_complete"}, 64'(complete), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_bad"}, 64'(bad_dest), 0);
        check({tag, "_offaddr"}, 64'(bus.offset_addr), 0);
        check({tag, "_edgeaddr"}, 64'(bus.edge_addr), 0);
    endtask

    // One scatter pass for table entry vi; optionally pulses start mid-pass
    // or drops reset during the second ready pulse.
    task automatic run_pass(input int vi, input bit inj, input bit rst_mid);
        int  cyc;
        bit  stop, overlap;
        vec_t v;
        v = vecs[vi];
        for (int i = 0; i < 3; i++) offset_mem[i] = v.offs[i];
        for (int i = 0; i < E; i++) edge_mem[i] = (i < 4) ? v.edges[i] : 32'd0;
        rank_in = {v.rank[1], v.rank[0]};
        for (int i = 0; i < 8; i++) begin got_val[i] = '1; got_dst[i] = '1; end
        got_n = 0; first_lat = -1; last_rdy = -1; stop = 0; overlap = 0;
        addr_at_first = '1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        check($sformatf("v%0d_start_clears_complete", vi), 64'(complete), 0);
        check($sformatf("v%0d_start_clears_bad", vi), 64'(bad_dest), 0);
        check($sformatf("v%0d_busy", vi), 64'(busy), 1);
        while (!complete && cyc < 3000 && !stop) begin
            @(negedge clock);
            cyc++;
            start = inj && (cyc == 30 || cyc == 70);
            if (bus.pagerank_ready) begin
                if (got_n < 8) begin
                    got_val[got_n] = bus.page_rank_scatter;
                    got_dst[got_n] = bus.dest_id;
                end
                if (got_n == 0) begin
                    first_lat = cyc;
                    addr_at_first = bus.edge_addr;
                end
                got_n++;
                last_rdy = cyc;
                if (complete) overlap = 1;
                if (rst_mid && got_n == 2) begin
                    reset_n = 1'b0;
                    #1;
                    check_reset_outputs("midreset");
                    stop = 1;
                end
            end
        end
        start = 1'b0;
        if (!rst_mid) begin
            check($sformatf("v%0d_completes", vi), 64'(complete), 1);
            check($sformatf("v%0d_pulse_count", vi), 64'(got_n), 64'(v.n));
            for (int i = 0; i < v.n; i++) begin
                check($sformatf("v%0d_value%0d", vi, i), got_val[i], v.val[i]);
                check($sformatf("v%0d_dest%0d", vi, i), 64'(got_dst[i]), 64'(v.dst[i]));
            end
            check($sformatf("v%0d_first_latency", vi), 64'(first_lat), 64'(v.lat));
            check($sformatf("v%0d_no_ready_with_complete", vi), 64'(overlap), 0);
            check($sformatf("v%0d_complete_after_last", vi), 64'(last_rdy < cyc), 1);
            check($sformatf("v%0d_bad_dest", vi), 64'(bad_dest), 64'(v.bad));
            if (vi == 6) begin
                check("deg4_consecutive", 64'(last_rdy - first_lat), 3);
                check("deg4_addr_at_first_ready", 64'(addr_at_first), 2);
            end
            repeat (3) @(negedge clock);
            check($sformatf("v%0d_complete_held", vi), 64'(complete), 1);
            check($sformatf("v%0d_bad_sticky", vi), 64'(bad_dest), 64'(v.bad));
        end
    endtask

    initial begin
        vecs[0] = mk(0, 2, 3, 1, 0, 0, 0, 100, 60, 3, 50, 50, 60, 0, 1, 0, 0, 0, 0, 71);
        vecs[1] = mk(0, 3, 3, 1, 0, 1, 0, 10, 5, 3, 3, 3, 3, 0, 1, 0, 1, 0, 0, 71);
        vecs[2] = mk(0, 0, 1, 0, 0, 0, 0, 77, 40, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0, 74);
        vecs[3] = mk(0, 2, 2, 5, 1, 0, 0, 8, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 1, 72);
        vecs[4] = mk(0, 1, 2, 1, 0, 0, 0, 0, 9, 2, 0, 9, 0, 0, 1, 0, 0, 0, 0, 71);
        vecs[5] = mk(0, 2, 1, 1, 1, 0, 0, 6, 7, 2, 3, 3, 0, 0, 1, 1, 0, 0, 0, 71);
        vecs[6] = mk(0, 4, 4, 0, 1, 1, 0, 100, 0, 4, 25, 25, 25, 25, 0, 1, 1, 0, 0, 71);

        reset_n = 1'b0;
        start   = 1'b0;
        rank_in = '0;
        for (int i = 0; i < 3; i++) offset_mem[i] = '0;
        for (int i = 0; i < E; i++) edge_mem[i] = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_not_busy", 64'(busy), 0);

        for (int vi = 0; vi < 7; vi++) run_pass(vi, 1'b0, 1'b0);

        // start pulses during DIV and EMIT must not disturb the pass
        run_pass(6, 1'b1, 1'b0);

        // reset in the middle of emission, then a clean rerun
        run_pass(6, 1'b0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("after_midreset_idle", 64'(busy), 0);
        check("after_midreset_ready", 64'(bus.pagerank_ready), 0);
        run_pass(6, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
